apb_cmd_sequencer: RTL and testbench

- Upstream command stage for apb_bridge: accepts single read/write commands on a valid/ready port and buffers them in a small FIFO.
- Replays each command onto the bridge master-side inputs (trnsfr, wr, dsel, address, data_in) and holds it until the bridge signals ready.
- Returns one response per command: read data, error flag, timeout flag.
- Replaces the hand-timed testbench tasks with a real, ready-paced driver for system use.

---
 rtl/apb_cmd_sequencer_pkg.sv | 35 +++
 rtl/apb_cmd_sequencer_if.sv | 26 ++
 rtl/apb_cmd_fifo.sv | 57 +++++
 rtl/apb_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_cmd_sequencer_pkg.sv
// Shared types for the APB command sequencer: data-size codes, FSM states and
// the queued command record.
package apb_seq_pkg;

  localparam int SEQ_ADDR_W = 32;
  localparam int SEQ_DATA_W = 32;

  typedef enum logic [1:0] {
    FULLWORD = 2'd0,
    HALFWORD = 2'd1,
    BYTE     = 2'd2
  } dsel_type;

  // Code 3 has no enum member; it is the size the bridge cannot perform.
  localparam logic [1:0] DSEL_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            dsel;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [SEQ_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic dsel_legal(input logic [1:0] d);
    return d != DSEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// Master-side signal bundle between the command sequencer and apb_bridge.
interface apb_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  trnsfr;
  logic                  wr;
  logic [1:0]            dsel;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  br_ready;
  logic                  br_slverr;
  logic [DATA_WIDTH-1:0] data_out;

  // Request is held (trnsfr, wr, dsel, address, data_in stable) until the
  // bridge answers with a one-cycle br_ready; br_slverr/data_out valid with it.
  modport master (
    output trnsfr, wr, dsel, address, data_in,
    input  br_ready, br_slverr, data_out
  );

  modport slave (
    input  trnsfr, wr, dsel, address, data_in,
    output br_ready, br_slverr, data_out
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally because depth is a power of two.
module apb_cmd_fifo
  import apb_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  cmd_t                          wdata,
  output cmd_t                          rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Queues single read/write commands and replays each onto the apb_bridge
// master inputs, returning one in-order response per command.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_W,
  parameter int DATA_WIDTH = SEQ_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  // Command port: a command transfers on an edge where cmd_valid && cmd_ready.
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_wr,
  input  logic [1:0]                    cmd_dsel,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  apb_cmd_sequencer_if.master           bus,
  output logic                          rsp_valid,
  output logic                          rsp_wr,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output seq_state_t                    state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  cmd_t          head;
  cmd_t          cur;
  cmd_t          cmd_in;
  logic          full;
  logic          empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          load;
  logic          fin_ok;
  logic          fin_tmo;
  logic          fin_ill;
  logic [CW-1:0] cnt;

  assign cmd_in    = '{wr: cmd_wr, dsel: cmd_dsel, addr: cmd_addr, wdata: cmd_wdata};
  assign fifo_push = cmd_valid && !full;
  assign cmd_ready = !full;

  apb_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (cmd_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // IDLE and RESP share the head-load decision so back-to-back commands
  // skip IDLE and sustain one command per three cycles.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    fin_ok    = 1'b0;
    fin_tmo   = 1'b0;
    fin_ill   = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (!empty) begin
          load = 1'b1;
          if (dsel_legal(head.dsel)) begin
            state_nxt = SETUP;
          end else begin
            fifo_pop  = 1'b1;
            fin_ill   = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (bus.br_ready) begin
          fifo_pop  = 1'b1;
          fin_ok    = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fifo_pop  = 1'b1;
          fin_tmo   = 1'b1;
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= '0;
      cnt         <= '0;
      rsp_wr      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (load) cur <= head;
      // Counter saturates at TIMEOUT so a stuck ACCESS can never wrap it.
      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS && cnt != CW'(TIMEOUT)) begin
        cnt <= cnt + 1'b1;
      end
      if (fin_ok) begin
        rsp_wr      <= cur.wr;
        rsp_rdata   <= (cur.wr || bus.br_slverr) ? '0 : bus.data_out;
        rsp_err     <= bus.br_slverr;
        rsp_timeout <= 1'b0;
      end else if (fin_tmo) begin
        rsp_wr      <= cur.wr;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end else if (fin_ill) begin
        rsp_wr      <= head.wr;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b0;
      end
    end
  end

  assign bus.trnsfr  = (state == SETUP) || (state == ACCESS);
  assign bus.wr      = cur.wr;
  assign bus.dsel    = cur.dsel;
  assign bus.address = cur.addr;
  assign bus.data_in = cur.wdata;
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE) || !empty;
  assign state_dbg   = state;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with an address-keyed bridge responder
// and an in-order response scoreboard.
module tb_apb_cmd_sequencer;
  import apb_seq_pkg::*;

  localparam logic [31:0] ERR_ADDR  = 32'h100;
  localparam logic [31:0] TMO_ADDR  = 32'h300;
  localparam logic [31:0] WAIT_ADDR = 32'h3D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [1:0]  cmd_dsel = 2'd0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [2:0]  fifo_level;
  logic        busy;
  seq_state_t  state_dbg;

  int total = 0;
  int bad = 0;
  int rsp_seen = 0;
  int cyc_cnt = 0;
  int last_rsp_cyc = 0;
  int last_gap = 0;
  int acc_cnt = 0;
  logic hold_ready = 1'b0;
  logic [34:0] exp_q[$];
  logic [34:0] exp_e;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  apb_cmd_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_cmd_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_dsel(cmd_dsel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .bus(bus),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .fifo_level(fifo_level), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic int waits_for(input logic [31:0] a);
    return (a == WAIT_ADDR) ? 3 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bridge model: ready after a per-address number of wait cycles, never for TMO_ADDR.
  always @(negedge clk) begin
    if (rst || !bus.trnsfr) acc_cnt = 0;
    else acc_cnt++;
    bus.br_ready  = 1'b0;
    bus.br_slverr = 1'b0;
    bus.data_out  = 32'hDEAD_BEEF;
    if (bus.trnsfr && !rst && !hold_ready && bus.address != TMO_ADDR &&
        acc_cnt >= waits_for(bus.address) + 2) begin
      bus.br_ready  = 1'b1;
      bus.br_slverr = (bus.address == ERR_ADDR);
      if (bus.wr) mem[bus.address] = bus.data_in;
      else bus.data_out = mem.exists(bus.address) ? mem[bus.address] : pattern(bus.address);
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_seen++;
      last_gap = cyc_cnt - last_rsp_cyc;
      last_rsp_cyc = cyc_cnt;
      check("rsp_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("rsp_fields", 64'({rsp_wr, rsp_err, rsp_timeout, rsp_rdata}), 64'(exp_e));
      end
    end
  end

  // driver tasks
  task automatic push_cmd(input logic w, input logic [1:0] d, input logic [31:0] a,
                          input logic [31:0] wd);
    logic got;
    logic err;
    logic tmo;
    logic [31:0] rd;
    cmd_wr = w; cmd_dsel = d; cmd_addr = a; cmd_wdata = wd;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      got = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("push_accepted", 64'(got), 1);
    if (got) begin
      err = (d == 2'd3) || (a == ERR_ADDR) || (a == TMO_ADDR);
      tmo = (d != 2'd3) && (a == TMO_ADDR);
      rd  = (w || err) ? 32'h0 : (shadow.exists(a) ? shadow[a] : pattern(a));
      if (w && !err) shadow[a] = wd;
      exp_q.push_back({w, err, tmo, rd});
    end
  endtask

  task automatic drain(input string tag, output int tcyc);
    int n;
    n = 0;
    tcyc = 0;
    while (busy && n < 400) begin
      if (bus.trnsfr) tcyc++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 0);
    check({tag, "_drained"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    int lat;
    int tcyc;
    int base;
    int cyc;
    logic stable;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_bus_ctrl", 64'({bus.trnsfr, bus.wr, bus.dsel}), 0);
    check("rst_address", 64'(bus.address), 0);
    check("rst_data_in", 64'(bus.data_in), 0);
    check("rst_rsp_flags", 64'({rsp_valid, rsp_wr, rsp_err, rsp_timeout, busy}), 0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 0);
    check("rst_level", 64'(fifo_level), 0);
    check("rst_cmd_ready", 64'(cmd_ready), 1);

    // Zero-wait write then read-back; latency counted from the push cycle.
    push_cmd(1'b1, FULLWORD, 32'hF0, 32'h000A_3210);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("wr_latency", 64'(lat), 4);
    drain("wr", tcyc);
    push_cmd(1'b0, FULLWORD, 32'hF0, 32'h0);
    drain("rd", tcyc);
    check("rd_trnsfr_cycles", 64'(tcyc), 2);

    // Queue fill with ready held off, then release and check in-order drain.
    base = rsp_seen;
    hold_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, FULLWORD, 32'h11 + 32'(i), 32'h0);
    check("fill_cmd_ready", 64'(cmd_ready), 0);
    check("fill_level", 64'(fifo_level), 4);
    fork
      push_cmd(1'b0, FULLWORD, 32'h15, 32'h0);
      begin repeat (6) @(posedge clk); #1 hold_ready = 1'b0; end
    join
    drain("fill", tcyc);
    check("fill_rsp_count", 64'(rsp_seen - base), 5);
    check("fill_b2b_gap", 64'(last_gap), 3);

    // Wait states: request must stay stable through the whole access.
    base = rsp_seen;
    push_cmd(1'b0, BYTE, WAIT_ADDR, 32'h0);
    cyc = 0;
    for (int n = 0; n < 20 && !bus.trnsfr; n++) begin @(posedge clk); #1; end
    stable = 1'b1;
    while (bus.trnsfr && cyc < 50) begin
      stable &= (bus.address == WAIT_ADDR) && (bus.dsel == 2'd2) && !bus.wr;
      cyc++;
      @(posedge clk); #1;
    end
    check("ws_trnsfr_cycles", 64'(cyc), 5);
    check("ws_stable", 64'(stable), 1);
    drain("ws", tcyc);
    check("ws_one_rsp", 64'(rsp_seen - base), 1);

    // Slave error on a read.
    push_cmd(1'b0, FULLWORD, ERR_ADDR, 32'h0);
    drain("slverr", tcyc);

    // Timeout after 16 ACCESS cycles, then the next command proceeds.
    push_cmd(1'b0, FULLWORD, TMO_ADDR, 32'h0);
    push_cmd(1'b1, FULLWORD, 32'h304, 32'h1234_5678);
    drain("tmo", tcyc);
    check("tmo_trnsfr_cycles", 64'(tcyc), 19);
    push_cmd(1'b0, FULLWORD, 32'h304, 32'h0);
    drain("tmo_next", tcyc);

    // Illegal size: no bus access for it; the following write is normal.
    push_cmd(1'b1, 2'd3, 32'h200, 32'h0000_0BAD);
    push_cmd(1'b1, FULLWORD, 32'h204, 32'hCAFE_0204);
    drain("ill", tcyc);
    check("ill_trnsfr_cycles", 64'(tcyc), 2);
    push_cmd(1'b0, FULLWORD, 32'h204, 32'h0);
    drain("ill_next", tcyc);

    // Reset while in ACCESS with a second command queued.
    push_cmd(1'b0, FULLWORD, TMO_ADDR, 32'h0);
    push_cmd(1'b1, FULLWORD, 32'h308, 32'h0000_0308);
    repeat (4) @(posedge clk);
    #1 check("pre_rst_trnsfr", 64'(bus.trnsfr), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_trnsfr", 64'(bus.trnsfr), 0);
    check("mid_rst_level", 64'(fifo_level), 0);
    check("mid_rst_flags", 64'({rsp_valid, busy}), 0);
    base = rsp_seen;
    repeat (20) @(posedge clk);
    #1 check("mid_rst_no_rsp", 64'(rsp_seen - base), 0);
    push_cmd(1'b1, HALFWORD, 32'h400, 32'h0BAD_F00D);
    push_cmd(1'b0, HALFWORD, 32'h400, 32'h0);
    drain("post_rst", tcyc);
    check("post_rst_trnsfr_cycles", 64'(tcyc), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
